// File: rtl/volume_history_ctrl.sv
// Peak-meter history for the record/speak OLED: turns mic samples into 16 columns of
// 4-bit peak levels and sequences record/freeze/clear from the push-to-talk button.
module volume_history_ctrl #(
    parameter int SAMPLE_W = 12,
    parameter int WINDOW   = 2000,
    parameter int CNT_W    = 11
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic                btn_speak,
    input  logic                clear,
    output logic [79:0]         volume,
    output logic                recording,
    output logic                col_strobe,
    output logic [4:0]          peak_level
);

    localparam int NCOL = 16;
    localparam logic [SAMPLE_W-1:0] MID     = {1'b1, {(SAMPLE_W-1){1'b0}}};
    localparam logic [SAMPLE_W-1:0] MAG_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic [CNT_W-1:0]    LAST    = CNT_W'(WINDOW - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RECORD = 2'd1,
        ST_FREEZE = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic               btn_prev_reg;
    logic [3:0]         col_reg  [NCOL];
    logic [3:0]         col_next [NCOL];
    logic [3:0]         peak_reg, peak_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               col_strobe_reg, col_strobe_next;

    logic               btn_press, btn_release;
    logic [SAMPLE_W-1:0] mag;
    logic [3:0]         level;
    logic [3:0]         merged_peak;
    logic               window_done;

    assign btn_press   = btn_speak & ~btn_prev_reg;
    assign btn_release = ~btn_speak & btn_prev_reg;

    // Distance from mid-scale; the single out-of-range code (full negative) saturates.
    always_comb begin
        mag         = (sample >= MID) ? (sample - MID) : (MID - sample);
        level       = (mag > MAG_MAX) ? 4'hF : mag[SAMPLE_W-2 -: 4];
        merged_peak = (level > peak_reg) ? level : peak_reg;
        window_done = sample_valid && (cnt_reg == LAST);
    end

    always_comb begin
        state_next      = state_reg;
        peak_next       = peak_reg;
        cnt_next        = cnt_reg;
        col_strobe_next = 1'b0;
        for (int i = 0; i < NCOL; i++) begin
            col_next[i] = col_reg[i];
        end

        if (clear) begin
            state_next = ST_IDLE;
            peak_next  = 4'd0;
            cnt_next   = '0;
            for (int i = 0; i < NCOL; i++) begin
                col_next[i] = 4'd0;
            end
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (btn_press) begin
                        state_next = ST_RECORD;
                        peak_next  = 4'd0;
                        cnt_next   = '0;
                    end
                end
                ST_RECORD: begin
                    if (sample_valid) begin
                        if (window_done) begin
                            // The closing sample counts toward the column it completes.
                            for (int i = 0; i < NCOL - 1; i++) begin
                                col_next[i] = col_reg[i+1];
                            end
                            col_next[NCOL-1] = merged_peak;
                            col_strobe_next  = 1'b1;
                            peak_next        = 4'd0;
                            cnt_next         = '0;
                        end else begin
                            peak_next = merged_peak;
                            cnt_next  = cnt_reg + CNT_W'(1);
                        end
                    end
                    // A release still lets a same-cycle shift land; only the partial window is dropped.
                    if (btn_release) begin
                        state_next = ST_FREEZE;
                        peak_next  = 4'd0;
                        cnt_next   = '0;
                    end
                end
                ST_FREEZE: begin
                    peak_next = 4'd0;
                    cnt_next  = '0;
                    if (btn_press) begin
                        state_next = ST_RECORD;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    peak_next  = 4'd0;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            btn_prev_reg   <= 1'b0;
            peak_reg       <= 4'd0;
            cnt_reg        <= '0;
            col_strobe_reg <= 1'b0;
            for (int i = 0; i < NCOL; i++) begin
                col_reg[i] <= 4'd0;
            end
        end else begin
            state_reg      <= state_next;
            btn_prev_reg   <= btn_speak;
            peak_reg       <= peak_next;
            cnt_reg        <= cnt_next;
            col_strobe_reg <= col_strobe_next;
            for (int i = 0; i < NCOL; i++) begin
                col_reg[i] <= col_next[i];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NCOL; gi++) begin : g_cols
            assign volume[gi*5 +: 5] = {1'b0, col_reg[gi]};
        end
    endgenerate

    assign recording  = (state_reg == ST_RECORD);
    assign col_strobe = col_strobe_reg;
    assign peak_level = recording ? {1'b0, peak_reg} : 5'd0;

endmodule

// File: tb/tb_volume_history_ctrl.sv
// Bench for volume_history_ctrl (WINDOW=4): directed steps plus random traffic, checked
// against a window/history model built from queues and plain arithmetic.
module tb_volume_history_ctrl;

    localparam int WIN = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_valid = 1'b0;
    logic [11:0] sample = 12'd2048;
    logic        btn_speak = 1'b0;
    logic        clear = 1'b0;
    logic [79:0] volume;
    logic        recording;
    logic        col_strobe;
    logic [4:0]  peak_level;

    volume_history_ctrl #(
        .SAMPLE_W (12),
        .WINDOW   (WIN),
        .CNT_W    (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample       (sample),
        .btn_speak    (btn_speak),
        .clear        (clear),
        .volume       (volume),
        .recording    (recording),
        .col_strobe   (col_strobe),
        .peak_level   (peak_level)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int strobe_seen = 0;

    // Reference model: 0 idle, 1 record, 2 freeze
    int m_mode;
    bit m_btn_prev;
    int m_hist[16];
    int m_win[$];
    bit m_strobe;

    function automatic int lvl(input int s);
        int m;
        m = (s >= 2048) ? s - 2048 : 2048 - s;
        if (m > 2047) m = 2047;
        return m / 128;
    endfunction

    function automatic int win_max();
        int mx = 0;
        foreach (m_win[i]) if (m_win[i] > mx) mx = m_win[i];
        return mx;
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_btn_prev = 1'b0;
        m_strobe = 1'b0;
        m_win.delete();
        for (int i = 0; i < 16; i++) m_hist[i] = 0;
    endtask

    task automatic model_step();
        bit press, rel;
        press = btn_speak && !m_btn_prev;
        rel = !btn_speak && m_btn_prev;
        m_btn_prev = btn_speak;
        m_strobe = 1'b0;
        if (clear) begin
            m_mode = 0;
            m_win.delete();
            for (int i = 0; i < 16; i++) m_hist[i] = 0;
        end else if (m_mode == 0) begin
            if (press) begin
                m_mode = 1;
                m_win.delete();
            end
        end else if (m_mode == 1) begin
            if (sample_valid) begin
                m_win.push_back(lvl(int'(sample)));
                if (m_win.size() == WIN) begin
                    int mx;
                    mx = win_max();
                    for (int i = 0; i < 15; i++) m_hist[i] = m_hist[i+1];
                    m_hist[15] = mx;
                    m_strobe = 1'b1;
                    m_win.delete();
                end
            end
            if (rel) begin
                m_mode = 2;
                m_win.delete();
            end
        end else begin
            m_win.delete();
            if (press) m_mode = 1;
        end
    endtask

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_all();
        logic [79:0] ev;
        for (int i = 0; i < 16; i++) ev[i*5 +: 5] = 5'(m_hist[i]);
        chk("volume", volume, ev);
        chk("recording", 80'(recording), 80'(m_mode == 1));
        chk("col_strobe", 80'(col_strobe), 80'(m_strobe));
        chk("peak_level", 80'(peak_level), 80'((m_mode == 1) ? win_max() : 0));
        if (col_strobe === 1'b1) strobe_seen++;
    endtask

    task automatic drive(input bit v, input int s, input bit b, input bit c);
        sample_valid = v;
        sample = 12'(s);
        btn_speak = b;
        clear = c;
        model_step();
        @(posedge clk);
        #1;
        check_all();
        $display("t=%0t valid=%0b sample=%0d btn=%0b clr=%0b -> rec=%0b strobe=%0b peak=%0d vol=%0h",
                 $time, v, s, b, c, recording, col_strobe, peak_level, volume);
    endtask

    initial begin
        logic [79:0] all3;
        for (int i = 0; i < 16; i++) all3[i*5 +: 5] = 5'd3;

        // Reset state
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // Idle: samples ignored
        for (int i = 0; i < 8; i++) drive(1'b1, int'($urandom_range(0, 4095)), 1'b0, 1'b0);

        // First window: levels 0, 3, 15, 0
        drive(1'b0, 2048, 1'b1, 1'b0);
        drive(1'b1, 2048, 1'b1, 1'b0);
        drive(1'b1, 2432, 1'b1, 1'b0);
        drive(1'b1, 0,    1'b1, 1'b0);
        drive(1'b1, 2100, 1'b1, 1'b0);
        chk("newest_col", 80'(volume[79:75]), 80'd15);
        chk("older_cols", 80'(volume[74:0]), 80'd0);
        chk("first_strobe", 80'(col_strobe), 80'd1);
        chk("peak_after_shift", 80'(peak_level), 80'd0);

        // 17 windows of level 3 with random idle gaps
        strobe_seen = 0;
        for (int w = 0; w < 17; w++) begin
            for (int k = 0; k < WIN; k++) begin
                while ($urandom_range(0, 3) == 0) drive(1'b0, 2432, 1'b1, 1'b0);
                drive(1'b1, 2432, 1'b1, 1'b0);
            end
        end
        drive(1'b0, 2048, 1'b1, 1'b0);
        chk("strobe_count", 80'(strobe_seen), 80'd17);
        chk("all_cols_3", volume, all3);

        // Partial window then release: discarded
        drive(1'b1, 4095, 1'b1, 1'b0);
        drive(1'b1, 4095, 1'b1, 1'b0);
        drive(1'b0, 2048, 1'b0, 1'b0);
        chk("freeze_peak", 80'(peak_level), 80'd0);
        chk("freeze_rec", 80'(recording), 80'd0);
        chk("freeze_vol", volume, all3);
        drive(1'b1, 4095, 1'b0, 1'b0);
        drive(1'b0, 2048, 1'b1, 1'b0);
        for (int k = 0; k < WIN; k++) drive(1'b1, 2048, 1'b1, 1'b0);
        chk("resume_newest", 80'(volume[79:75]), 80'd0);
        chk("resume_older", 80'(volume[74:0]), 80'(all3[79:5]));

        // Clear beats the window-closing sample
        for (int k = 0; k < WIN - 1; k++) drive(1'b1, 2432, 1'b1, 1'b0);
        drive(1'b1, 2432, 1'b1, 1'b1);
        chk("clear_vol", volume, 80'd0);
        chk("clear_strobe", 80'(col_strobe), 80'd0);
        chk("clear_rec", 80'(recording), 80'd0);

        // Press coinciding with clear is lost
        drive(1'b0, 2048, 1'b0, 1'b0);
        drive(1'b0, 2048, 1'b1, 1'b1);
        drive(1'b1, 0, 1'b1, 1'b0);
        chk("press_lost", 80'(recording), 80'd0);

        // Random traffic
        begin
            bit b = 1'b0;
            for (int n = 0; n < 800; n++) begin
                int s;
                if ($urandom_range(0, 29) == 0) b = ~b;
                case ($urandom_range(0, 3))
                    0: s = 0;
                    1: s = 4095;
                    default: s = int'($urandom_range(0, 4095));
                endcase
                drive($urandom_range(0, 3) != 0, s, b, $urandom_range(0, 199) == 0);
            end
        end

        // Button held through reset release
        #2;
        rst_n = 1'b0;
        btn_speak = 1'b1;
        sample_valid = 1'b0;
        clear = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        drive(1'b0, 2048, 1'b1, 1'b0);
        chk("held_btn_rec", 80'(recording), 80'd1);

        // Asynchronous reset mid-window
        for (int k = 0; k < WIN + 2; k++) drive(1'b1, 0, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_vol", volume, 80'd0);
        chk("async_rec", 80'(recording), 80'd0);
        chk("async_peak", 80'(peak_level), 80'd0);
        chk("async_strobe", 80'(col_strobe), 80'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
